// File: rtl/screen_pkg.sv
// Shared constants for the 32x32 LED matrix framebuffer path: register map,
// CTRL strobe bit positions, controller FSM encoding and default widths
// (also used by screen32x32).
package screen_pkg;

  localparam int DEF_COLOR_W = 24;
  localparam int DEF_XY_W    = 5;
  localparam int BUS_AW      = 5;
  localparam int BUS_DW      = 32;

  localparam logic [BUS_AW-1:0] REG_CTRL   = 5'h00;
  localparam logic [BUS_AW-1:0] REG_X      = 5'h04;
  localparam logic [BUS_AW-1:0] REG_Y      = 5'h08;
  localparam logic [BUS_AW-1:0] REG_COLOR  = 5'h0C;
  localparam logic [BUS_AW-1:0] REG_STATUS = 5'h10;

  localparam int CTRL_PIX     = 0;
  localparam int CTRL_FILL    = 1;
  localparam int CTRL_SWAP    = 2;
  localparam int CTRL_CLR_ERR = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PIXEL = 2'd1,
    ST_FILL  = 2'd2
  } state_t;

endpackage

// File: rtl/screen_fb_ctrl_if.sv
// CPU register bus seen by the framebuffer controller.
// Bus semantics: rd and wr are single-cycle strobes that only count while cs
// is high; the peripheral never stalls, so every cs&wr is accepted on the edge
// it is sampled and every cs&rd returns d_out on the following cycle, where it
// stays until the next read.
interface screen_fb_ctrl_if;
  import screen_pkg::*;

  logic              cs;
  logic              rd;
  logic              wr;
  logic [BUS_AW-1:0] addr;
  logic [BUS_DW-1:0] d_in;
  logic [BUS_DW-1:0] d_out;

  modport master (output cs, rd, wr, addr, d_in, input d_out);
  modport slave  (input cs, rd, wr, addr, d_in, output d_out);
endinterface

// File: rtl/screen_fill_counter.sv
// Address counter for full-screen fills: counts while enabled, flags the last
// address and wraps back to zero after it.
module screen_fill_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         done
);

  // Advance once per enabled cycle; the natural wrap leaves 0 for the next fill.
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (en) count <= count + W'(1);
  end

  assign done = en && (count == {W{1'b1}});

endmodule

// File: rtl/screen_fb_ctrl.sv
// CPU-side framebuffer controller for the 32x32 LED matrix.
// Register-mapped pixel writes and full-screen fills into the shared
// framebuffer. Define SCREEN_DBUF_EN to enable double buffering (writes go to
// the back bank, SWAP takes effect on the next frame_done).
module screen_fb_ctrl
  import screen_pkg::*;
#(
  parameter int COLOR_W = DEF_COLOR_W,
  parameter int XY_W    = DEF_XY_W,
  parameter int FB_AW   = 2 * DEF_XY_W
) (
  input  logic               clk,
  input  logic               reset,
  screen_fb_ctrl_if.slave    bus,
  output logic               fb_we,
  output logic [FB_AW:0]     fb_addr,
  output logic [COLOR_W-1:0] fb_data,
  input  logic               frame_done,
  output logic               front_bank,
  output state_t             state_dbg
);

  state_t             state_q, state_d;
  logic [XY_W-1:0]    x_q, y_q;
  logic [COLOR_W-1:0] color_q;
  logic               err_q;
  logic               swap_pending_q;
  logic               front_bank_q;
  logic               bank_d;
  logic [FB_AW-1:0]   fill_cnt;
  logic               fill_done;
  logic               wr_en, rd_en, ctrl_wr, busy;
  logic               cmd_pix, cmd_fill, start_pix, start_fill;
  logic               unused_d_in;

  assign wr_en      = bus.cs & bus.wr;
  assign rd_en      = bus.cs & bus.rd;
  assign ctrl_wr    = wr_en && (bus.addr == REG_CTRL);
  assign cmd_pix    = ctrl_wr & bus.d_in[CTRL_PIX];
  assign cmd_fill   = ctrl_wr & bus.d_in[CTRL_FILL];
  assign busy       = (state_q != ST_IDLE);
  // FILL beats PIX when both strobes arrive together.
  assign start_fill = cmd_fill & ~busy;
  assign start_pix  = cmd_pix & ~cmd_fill & ~busy;

  assign unused_d_in = ^bus.d_in[BUS_DW-1:COLOR_W];

  // Parameter registers; writes while busy are taken and only affect later commands.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
    end else if (wr_en) begin
      if (bus.addr == REG_X)     x_q     <= bus.d_in[XY_W-1:0];
      if (bus.addr == REG_Y)     y_q     <= bus.d_in[XY_W-1:0];
      if (bus.addr == REG_COLOR) color_q <= bus.d_in[COLOR_W-1:0];
    end
  end

  // Sticky error: a command refused because the engine is busy.
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if ((cmd_pix | cmd_fill) & busy) err_q <= 1'b1;
    else if (ctrl_wr & bus.d_in[CTRL_CLR_ERR]) err_q <= 1'b0;
  end

`ifdef SCREEN_DBUF_EN
  logic front_bank_d;

  // A pending swap lands on frame_done; writes always aim at the bank not shown.
  assign front_bank_d = front_bank_q ^ (frame_done & swap_pending_q);
  assign bank_d       = ~front_bank_d;

  // Swap request and displayed-bank tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_pending_q <= 1'b0;
      front_bank_q   <= 1'b0;
    end else begin
      front_bank_q <= front_bank_d;
      if (frame_done & swap_pending_q) swap_pending_q <= 1'b0;
      else if (ctrl_wr & bus.d_in[CTRL_SWAP]) swap_pending_q <= 1'b1;
    end
  end
`else
  logic unused_frame_done;

  assign swap_pending_q    = 1'b0;
  assign front_bank_q      = 1'b0;
  assign bank_d            = 1'b0;
  assign unused_frame_done = frame_done;
`endif

  assign front_bank = front_bank_q;
  assign state_dbg  = state_q;

  screen_fill_counter #(.W(FB_AW)) u_fill_counter (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == ST_FILL),
    .count (fill_cnt),
    .done  (fill_done)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else state_q <= state_d;
  end

  // FSM next state: one cycle for a pixel, until the last address for a fill.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_fill) state_d = ST_FILL;
        else if (start_pix) state_d = ST_PIXEL;
      end
      ST_PIXEL: state_d = ST_IDLE;
      ST_FILL:  if (fill_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered framebuffer port; fb_data holds the fill colour captured at entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_data <= '0;
    end else begin
      fb_we <= (state_d != ST_IDLE);
      if (start_pix) begin
        fb_addr <= {bank_d, y_q, x_q};
        fb_data <= color_q;
      end else if (start_fill) begin
        fb_addr <= {bank_d, {FB_AW{1'b0}}};
        fb_data <= color_q;
      end else if (state_q == ST_FILL) begin
        fb_addr <= {bank_d, fill_cnt + FB_AW'(1)};
      end
    end
  end

  // Registered read port; unmapped offsets and CTRL read as zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.d_out <= '0;
    end else if (rd_en) begin
      case (bus.addr)
        REG_X:      bus.d_out <= {{(BUS_DW-XY_W){1'b0}}, x_q};
        REG_Y:      bus.d_out <= {{(BUS_DW-XY_W){1'b0}}, y_q};
        REG_COLOR:  bus.d_out <= {{(BUS_DW-COLOR_W){1'b0}}, color_q};
        REG_STATUS: bus.d_out <= {28'd0, err_q, front_bank_q, swap_pending_q, busy};
        default:    bus.d_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_screen_fb_ctrl.sv
// Directed bench for screen_fb_ctrl: pixel write, fills, busy/err handling,
// reset mid-fill, bank swap (SCREEN_DBUF_EN) and unmapped reads.
module tb_screen_fb_ctrl;
  import screen_pkg::*;

  localparam int EW = 11 + 24;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_done = 1'b0;
  logic        fb_we;
  logic [10:0] fb_addr;
  logic [23:0] fb_data;
  logic        front_bank;
  state_t      state_dbg;

  screen_fb_ctrl_if bus ();

  screen_fb_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .frame_done (frame_done),
    .front_bank (front_bank),
    .state_dbg  (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int wr_seen = 0;
  int run_len = 0;
  int last_run = 0;
  logic [EW-1:0] exp_q[$];

`ifdef SCREEN_DBUF_EN
  localparam logic EB = 1'b1;
`else
  localparam logic EB = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every framebuffer write must match the head of exp_q.
  always @(negedge clk) begin
    if (fb_we === 1'b1) begin
      wr_seen++;
      run_len++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write got=%0h exp=none", {fb_addr, fb_data});
      end else begin
        check("fb_write", {fb_addr, fb_data}, exp_q.pop_front());
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
    end
  end

  // Driver tasks
  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = a;
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd = 1'b0;
    d = bus.d_out;
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic push_fill(input logic bank, input logic [23:0] color);
    for (int i = 0; i < 1024; i++) exp_q.push_back({bank, 10'(i), color});
  endtask

  task automatic wait_idle(input string tag);
    logic ok = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (state_dbg == ST_IDLE && fb_we === 1'b0) begin ok = 1'b1; break; end
    end
    @(negedge clk);
    check(tag, ok, 1'b1);
  endtask

  initial begin
    logic found;
    int base;
    bus.cs = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.d_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", fb_we, 1'b0);
    check("rst_fb_addr", fb_addr, 11'h0);
    check("rst_fb_data", fb_data, 24'h0);
    check("rst_d_out", bus.d_out, 32'h0);
    check("rst_front", front_bank, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    reset = 1'b0;
    read_check("rst_status", REG_STATUS, 32'h0);
    read_check("rst_color", REG_COLOR, 32'h0);

    // Single pixel; upper bits of X/Y/COLOR are write-ignored
    bus_write(REG_X, 32'hFFFF_FFE3);
    bus_write(REG_Y, 32'h0000_0022);
    bus_write(REG_COLOR, 32'hAAFF_0000);
    read_check("x_mask", REG_X, 32'h3);
    read_check("y_mask", REG_Y, 32'h2);
    read_check("color_mask", REG_COLOR, 32'hFF_0000);
    exp_q.push_back({EB, 10'h043, 24'hFF0000});
    bus_write(REG_CTRL, 32'h1);
    check("pix_state", state_dbg, ST_PIXEL);
    read_check("pix_status_after", REG_STATUS, 32'h0);
    check("pix_drained", exp_q.size(), 0);
    check("pix_wr_count", wr_seen, 1);

    // Full fill with err handling and COLOR update in flight
    bus_write(REG_COLOR, 32'h0000_FF00);
    push_fill(EB, 24'h00FF00);
    bus_write(REG_CTRL, 32'h2);
    read_check("fill_busy", REG_STATUS, 32'h1);
    bus_write(REG_COLOR, 32'h0012_3456);
    bus_write(REG_CTRL, 32'h1);
    read_check("err_set", REG_STATUS, 32'h9);
    bus_write(REG_CTRL, 32'h8);
    read_check("err_clr", REG_STATUS, 32'h1);
    read_check("color_in_fill", REG_COLOR, 32'h12_3456);
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_addr[9:0] == 10'd1023) begin found = 1'b1; break; end
    end
    check("fill_last_addr", found, 1'b1);
    bus.cs = 1'b1; bus.rd = 1'b1; bus.addr = REG_STATUS;
    @(posedge clk); #1;
    check("busy_last_write", bus.d_out, 32'h1);
    @(posedge clk); #1;
    bus.cs = 1'b0; bus.rd = 1'b0;
    check("busy_after_fill", bus.d_out, 32'h0);
    check("fill_we_low", fb_we, 1'b0);
    check("fill_run", last_run, 1024);
    check("fill_drained", exp_q.size(), 0);
    check("fill_wr_count", wr_seen, 1025);

    // PIX+FILL together: FILL wins, uses COLOR written during the previous fill
    push_fill(EB, 24'h123456);
    bus_write(REG_CTRL, 32'h3);
    check("both_state", state_dbg, ST_FILL);
    wait_idle("both_idle");
    check("both_run", last_run, 1024);
    check("both_drained", exp_q.size(), 0);

    // Reset at fill address 500
    read_check("x_before_rst", REG_X, 32'h3);
    bus_write(REG_COLOR, 32'h0000_00FF);
    push_fill(EB, 24'h0000FF);
    base = wr_seen;
    bus_write(REG_CTRL, 32'h2);
    found = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_addr[9:0] == 10'd500) begin found = 1'b1; break; end
    end
    check("rst_fill_found", found, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    check("rstf_fb_we", fb_we, 1'b0);
    check("rstf_fb_addr", fb_addr, 11'h0);
    check("rstf_fb_data", fb_data, 24'h0);
    check("rstf_d_out", bus.d_out, 32'h0);
    check("rstf_state", state_dbg, ST_IDLE);
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstf_wr_count", wr_seen - base, 501);
    read_check("rstf_x", REG_X, 32'h0);
    read_check("rstf_y", REG_Y, 32'h0);
    read_check("rstf_color", REG_COLOR, 32'h0);
    read_check("rstf_status", REG_STATUS, 32'h0);

    // Bank swap
    bus_write(REG_X, 32'h5);
    bus_write(REG_Y, 32'h1);
    bus_write(REG_COLOR, 32'h00AB_CDEF);
    bus_write(REG_CTRL, 32'h4);
`ifdef SCREEN_DBUF_EN
    read_check("swap_pending", REG_STATUS, 32'h2);
`else
    read_check("swap_ignored", REG_STATUS, 32'h0);
`endif
    @(posedge clk); #1; frame_done = 1'b1;
    @(posedge clk); #1; frame_done = 1'b0;
`ifdef SCREEN_DBUF_EN
    check("front_swapped", front_bank, 1'b1);
    read_check("swap_done_status", REG_STATUS, 32'h4);
`else
    check("front_tied", front_bank, 1'b0);
    read_check("status_no_swap", REG_STATUS, 32'h0);
`endif
    exp_q.push_back({1'b0, 10'h025, 24'hABCDEF});
    bus_write(REG_CTRL, 32'h1);
    wait_idle("swap_pix_idle");
    check("swap_pix_drained", exp_q.size(), 0);

    // Unmapped and write-only offsets read 0
    read_check("x_reads", REG_X, 32'h5);
    read_check("unmapped_14", 5'h14, 32'h0);
    read_check("y_reads", REG_Y, 32'h1);
    read_check("ctrl_reads_0", REG_CTRL, 32'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/screen_fb_ctrl.md
Name: screen_fb_ctrl

Overview:
CPU-side framebuffer controller for the 32x32 LED matrix peripheral; sits directly upstream of screen32x32.
- Takes memory-mapped register accesses from the rv32i bus.
- Generates framebuffer write traffic: single-pixel writes and full-screen fills.
- screen32x32 scans the same dual-port framebuffer; its frame_done pulse is used for optional bank swapping.

Parameters:
COLOR_W, 24, pixel colour width (RGB888)
XY_W, 5, coordinate width (32 = 2^5)
FB_AW, 10, framebuffer address width per bank (2*XY_W)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  peripheral chip select
rd  in  1  bus read strobe (qualified by cs)
wr  in  1  bus write strobe (qualified by cs)
addr  in  5  byte offset; word registers at 0x00/04/08/0C/10
d_in  in  32  bus write data
d_out  out  32  bus read data
fb_we  out  1  framebuffer write enable
fb_addr  out  FB_AW+1  framebuffer address; MSB = bank select
fb_data  out  COLOR_W  framebuffer write data
frame_done  in  1  one-cycle pulse from screen32x32 at end of frame
front_bank  out  1  bank screen32x32 displays

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high on `reset`.
- Registers:
  - 0x00 CTRL, write-only, self-clearing strobes: bit0 PIX, bit1 FILL, bit2 SWAP, bit3 CLR_ERR.
  - 0x04 X[4:0]; 0x08 Y[4:0]; 0x0C COLOR[COLOR_W-1:0]. All read/write; unused upper bits write-ignored and read 0.
  - 0x10 STATUS, read-only: bit0 busy, bit1 swap_pending, bit2 front_bank, bit3 err.
- Reset values: X=Y=COLOR=0; d_out=0; fb_we=0; fb_addr=0; fb_data=0; front_bank=0; swap_pending=0; err=0; FSM=IDLE.
- Reads are registered: d_out is valid on the cycle after cs&rd is sampled and holds until the next read. Unmapped offsets read 0.
- Write priority: a CTRL write and an X/Y/COLOR write cannot coincide (single bus). PIX uses the X/Y/COLOR values already latched.
- FSM states: IDLE, PIXEL, FILL.
  - IDLE --PIX--> PIXEL. PIX and FILL both set in one write: FILL wins.
  - IDLE --FILL--> FILL.
  - PIXEL: fb_we=1 for exactly one cycle; fb_addr={bank,Y,X}; fb_data=COLOR; then IDLE.
  - FILL: 10-bit counter runs 0..1023. fb_we=1 for 1024 consecutive cycles; fb_addr low bits = counter; fb_data=COLOR sampled at FILL entry. After the write at address 1023, return to IDLE; the counter wraps to 0.
- Latency: CTRL write sampled at edge N -> first fb_we high during cycle N+1.
  - busy=1 from cycle N+1 through the last write cycle.
  - PIXEL: busy for 1 cycle. FILL: busy for 1024 cycles.
- PIX/FILL received while busy: ignored, err set. err is sticky until a CTRL write with bit3=1.
- COLOR/X/Y writes while busy: accepted. They affect only later commands, never the fill in progress.
- Reset mid-fill: aborts next edge with fb_we=0; partially written framebuffer content is left as-is.
- fb_we/fb_addr/fb_data are all registered outputs; fb_we is never high in IDLE.

Optional Feature:
Macro SCREEN_DBUF_EN (double buffering).
- Enabled:
  - Writes target the back bank: fb_addr MSB = ~front_bank.
  - SWAP sets swap_pending. On the next frame_done while pending, front_bank toggles and swap_pending clears in the same edge.
  - SWAP while already pending: no effect.
  - frame_done during FILL: the swap still occurs; the remaining fill writes go to the new back bank.
  - Reset clears pending and front_bank.
- Disabled:
  - fb_addr MSB tied 0; front_bank tied 0.
  - SWAP ignored; STATUS bits 1–2 read 0; frame_done unused.

Decomposition:
- Package screen_pkg holds:
  - register offset constants REG_CTRL/REG_X/REG_Y/REG_COLOR/REG_STATUS;
  - CTRL bit indices;
  - FSM state encoding;
  - COLOR_W/XY_W defaults (shared with screen32x32).
- One natural sub-module: screen_fill_counter, the 10-bit counter with enable, done flag and wrap.
- Everything else stays flat.

Test Plan:
- Reset, then write X=3, Y=2, COLOR=0xFF0000, CTRL=0x1 -> one fb_we cycle, fb_addr=0x043, fb_data=0xFF0000; STATUS=0 afterwards.
- Write COLOR=0x00FF00, CTRL=0x2 -> 1024 consecutive fb_we cycles, addresses 0..1023, data 0x00FF00. STATUS busy=1 during the fill and 0 the cycle after address 1023.
- During FILL, write CTRL=0x1 -> ignored, STATUS.err=1. CTRL=0x8 -> err=0.
- Assert reset at fill address 500 -> fb_we=0 next cycle; all registers return to reset values.
- SCREEN_DBUF_EN: CTRL=0x4 -> swap_pending=1. frame_done pulse -> front_bank=1, pending=0. Next pixel write has fb_addr MSB=0.
- Read unmapped offset 0x14 -> d_out=0 one cycle after rd.
